// File: rtl/wb_port_arbiter_if.sv
// Bundle of writeback, multi-cycle result, decode and register-file signals
// shared between the writeback port arbiter and its surroundings.
interface wb_port_arbiter_if;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  logic        mdu_issue;
  logic [4:0]  mdu_issue_rd;
  logic        mdu_valid;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_data;
  logic        mdu_ready;

  logic [4:0]  dec_rs;
  logic [4:0]  dec_rt;
  logic [4:0]  dec_rd;
  logic        hazard;
  logic        pipe_stall;

  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wd;
  logic [1:0]  fifo_count;
  logic [31:0] pend_mask;

  modport slave (
    input  wb_we, wb_rd, wb_data,
    input  mdu_issue, mdu_issue_rd, mdu_valid, mdu_rd, mdu_data,
    input  dec_rs, dec_rt, dec_rd,
    output mdu_ready, hazard, pipe_stall,
    output rf_we, rf_rd, rf_wd, fifo_count, pend_mask
  );

  modport master (
    output wb_we, wb_rd, wb_data,
    output mdu_issue, mdu_issue_rd, mdu_valid, mdu_rd, mdu_data,
    output dec_rs, dec_rt, dec_rd,
    input  mdu_ready, hazard, pipe_stall,
    input  rf_we, rf_rd, rf_wd, fifo_count, pend_mask
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares one register-file write port between the pipeline writeback stage and
// a 2-entry in-order FIFO of multi-cycle results, with a pending-write scoreboard.
module wb_port_arbiter (
  input  logic             clock,
  input  logic             reset,
  wb_port_arbiter_if.slave bus
);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } entry_t;

  typedef enum logic [1:0] {
    GRANT_IDLE,
    GRANT_WB,
    GRANT_FIFO
  } grant_e;

  entry_t      fifo_q [2];
  logic        head_q, head_d;
  logic        tail_q, tail_d;
  logic [1:0]  count_q, count_d;
  logic [1:0]  starve_q, starve_d;
  logic [31:0] pend_q, pend_d;
  logic        rf_we_q, rf_we_d;
  logic [4:0]  rf_rd_q, rf_rd_d;
  logic [31:0] rf_wd_q, rf_wd_d;

  grant_e      grant;
  entry_t      head_entry;
  logic        ready;
  logic        stall;
  logic        push;
  logic        pop;

  always_comb begin
    ready      = (count_q != 2'd2);
    stall      = (starve_q == 2'd3);
    head_entry = fifo_q[head_q];
    push       = bus.mdu_valid && ready && (bus.mdu_rd != '0);

    // A starved FIFO pre-empts the pipeline; wb_* is not even looked at then.
    grant = GRANT_IDLE;
    if (stall)
      grant = GRANT_FIFO;
    else if (bus.wb_we && (bus.wb_rd != '0))
      grant = GRANT_WB;
    else if (count_q != '0)
      grant = GRANT_FIFO;

    pop = (grant == GRANT_FIFO);
  end

  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    starve_d = starve_q;
    pend_d   = pend_q;
    rf_we_d  = 1'b0;
    rf_rd_d  = rf_rd_q;
    rf_wd_d  = rf_wd_q;

    if (push)
      tail_d = tail_q + 1'b1;
    if (pop)
      head_d = head_q + 1'b1;

    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    if (pop)
      starve_d = '0;
    else if ((count_q == 2'd2) && (starve_q != 2'd3))
      starve_d = starve_q + 2'd1;

    unique case (grant)
      GRANT_WB: begin
        rf_we_d = 1'b1;
        rf_rd_d = bus.wb_rd;
        rf_wd_d = bus.wb_data;
      end
      GRANT_FIFO: begin
        rf_we_d = 1'b1;
        rf_rd_d = head_entry.rd;
        rf_wd_d = head_entry.data;
      end
      default: ;
    endcase

    // Clear before set so a same-cycle re-issue keeps the bit pending.
    if (pop)
      pend_d[head_entry.rd] = 1'b0;
    if (bus.mdu_issue && (bus.mdu_issue_rd != '0))
      pend_d[bus.mdu_issue_rd] = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q   <= 1'b0;
      tail_q   <= 1'b0;
      count_q  <= '0;
      starve_q <= '0;
      pend_q   <= '0;
      rf_we_q  <= 1'b0;
      rf_rd_q  <= '0;
      rf_wd_q  <= '0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      pend_q   <= pend_d;
      rf_we_q  <= rf_we_d;
      rf_rd_q  <= rf_rd_d;
      rf_wd_q  <= rf_wd_d;
    end
  end

  // Storage needs no reset: an empty count makes stale entries unreachable.
  always_ff @(posedge clock) begin
    if (push)
      fifo_q[tail_q] <= '{rd: bus.mdu_rd, data: bus.mdu_data};
  end

  assign bus.mdu_ready  = ready;
  assign bus.pipe_stall = stall;
  assign bus.fifo_count = count_q;
  assign bus.pend_mask  = pend_q;
  assign bus.rf_we      = rf_we_q;
  assign bus.rf_rd      = rf_rd_q;
  assign bus.rf_wd      = rf_wd_q;
  assign bus.hazard     = ((bus.dec_rs != '0) && pend_q[bus.dec_rs]) ||
                          ((bus.dec_rt != '0) && pend_q[bus.dec_rt]) ||
                          ((bus.dec_rd != '0) && pend_q[bus.dec_rd]);

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios with literal expectations plus
// random traffic compared each cycle against a queue-based reference model.
module tb_wb_port_arbiter;

  logic clock;
  logic reset;

  wb_port_arbiter_if bus ();

  wb_port_arbiter dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, got, exp, $time);
  endtask

  // Reference model: port state after the most recent clock edge.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  int unsigned m_starve;
  logic [31:0] m_pend;
  logic        m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_wd;

  task automatic model_reset();
    mq.delete();
    m_starve = 0;
    m_pend   = '0;
    m_we     = 1'b0;
    m_rd     = '0;
    m_wd     = '0;
  endtask

  function automatic logic model_hazard();
    logic h;
    h = 1'b0;
    if (bus.dec_rs != 0 && m_pend[bus.dec_rs]) h = 1'b1;
    if (bus.dec_rt != 0 && m_pend[bus.dec_rt]) h = 1'b1;
    if (bus.dec_rd != 0 && m_pend[bus.dec_rd]) h = 1'b1;
    return h;
  endfunction

  task automatic model_step();
    int   old_size;
    logic can_accept;
    logic pop;
    ent_t e;
    old_size   = mq.size();
    can_accept = (old_size < 2);
    pop        = 1'b0;
    m_we       = 1'b0;
    if (m_starve == 3)
      pop = 1'b1;
    else if (bus.wb_we && bus.wb_rd != 0) begin
      m_we = 1'b1;
      m_rd = bus.wb_rd;
      m_wd = bus.wb_data;
    end else if (old_size > 0)
      pop = 1'b1;
    if (pop) begin
      e    = mq.pop_front();
      m_we = 1'b1;
      m_rd = e.rd;
      m_wd = e.data;
      m_pend[e.rd] = 1'b0;
    end
    if (bus.mdu_issue && bus.mdu_issue_rd != 0)
      m_pend[bus.mdu_issue_rd] = 1'b1;
    if (pop)
      m_starve = 0;
    else if (old_size == 2 && m_starve < 3)
      m_starve++;
    if (bus.mdu_valid && can_accept && bus.mdu_rd != 0) begin
      e.rd   = bus.mdu_rd;
      e.data = bus.mdu_data;
      mq.push_back(e);
    end
  endtask

  // Inputs are stable from posedge+1 to the next posedge, so the falling edge
  // sees both the settled outputs and the inputs about to be captured.
  always @(negedge clock) begin
    if (reset)
      model_reset();
    else begin
      chk("rf_we",      32'(bus.rf_we),      32'(m_we));
      chk("rf_rd",      32'(bus.rf_rd),      32'(m_rd));
      chk("rf_wd",      bus.rf_wd,           m_wd);
      chk("fifo_count", 32'(bus.fifo_count), 32'(mq.size()));
      chk("mdu_ready",  32'(bus.mdu_ready),  32'(mq.size() < 2));
      chk("pipe_stall", 32'(bus.pipe_stall), 32'(m_starve == 3));
      chk("pend_mask",  bus.pend_mask,       m_pend);
      chk("hazard",     32'(bus.hazard),     32'(model_hazard()));
      model_step();
    end
  end

  task automatic idle_in();
    bus.wb_we        = 1'b0;
    bus.wb_rd        = '0;
    bus.wb_data      = '0;
    bus.mdu_issue    = 1'b0;
    bus.mdu_issue_rd = '0;
    bus.mdu_valid    = 1'b0;
    bus.mdu_rd       = '0;
    bus.mdu_data     = '0;
    bus.dec_rs       = '0;
    bus.dec_rt       = '0;
    bus.dec_rd       = '0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rf_we"},      32'(bus.rf_we),      32'd0);
    chk({tag, "_rf_rd"},      32'(bus.rf_rd),      32'd0);
    chk({tag, "_rf_wd"},      bus.rf_wd,           32'd0);
    chk({tag, "_fifo_count"}, 32'(bus.fifo_count), 32'd0);
    chk({tag, "_pend_mask"},  bus.pend_mask,       32'd0);
    chk({tag, "_mdu_ready"},  32'(bus.mdu_ready),  32'd1);
    chk({tag, "_hazard"},     32'(bus.hazard),     32'd0);
    chk({tag, "_pipe_stall"}, 32'(bus.pipe_stall), 32'd0);
  endtask

  initial begin
    logic [4:0] r;
    reset = 1'b1;
    idle_in();
    repeat (2) @(posedge clock);
    #1;
    chk_reset_vals("reset");
    reset = 1'b0;
    tick();

    // Pipeline write on an idle FIFO lands one edge later.
    bus.wb_we = 1'b1; bus.wb_rd = 5'd5; bus.wb_data = 32'h1234;
    tick();
    bus.wb_we = 1'b0;
    chk("wb_rf_we", 32'(bus.rf_we), 32'd1);
    chk("wb_rf_rd", 32'(bus.rf_rd), 32'd5);
    chk("wb_rf_wd", bus.rf_wd, 32'h1234);

    // Scoreboard hazard lasts until the MDU result is written.
    bus.mdu_issue = 1'b1; bus.mdu_issue_rd = 5'd9; bus.dec_rs = 5'd9;
    tick();
    bus.mdu_issue = 1'b0;
    chk("sb_pend9", 32'(bus.pend_mask[9]), 32'd1);
    chk("sb_hazard_issued", 32'(bus.hazard), 32'd1);
    bus.mdu_valid = 1'b1; bus.mdu_rd = 5'd9; bus.mdu_data = 32'hBEEF;
    tick();
    bus.mdu_valid = 1'b0;
    chk("sb_hazard_queued", 32'(bus.hazard), 32'd1);
    chk("sb_count1", 32'(bus.fifo_count), 32'd1);
    tick();
    chk("sb_rf_we", 32'(bus.rf_we), 32'd1);
    chk("sb_rf_rd", 32'(bus.rf_rd), 32'd9);
    chk("sb_rf_wd", bus.rf_wd, 32'hBEEF);
    chk("sb_pend_clear", bus.pend_mask, 32'd0);
    chk("sb_hazard_clear", 32'(bus.hazard), 32'd0);
    bus.dec_rs = '0;

    // Register 0 writes from either source are dropped.
    bus.mdu_valid = 1'b1; bus.mdu_rd = 5'd0; bus.mdu_data = 32'h5555;
    bus.wb_we = 1'b1; bus.wb_rd = 5'd0; bus.wb_data = 32'h6666;
    tick();
    idle_in();
    chk("r0_rf_we", 32'(bus.rf_we), 32'd0);
    chk("r0_count", 32'(bus.fifo_count), 32'd0);

    // Push and pop in one cycle at count 1 keeps the count and the order.
    bus.mdu_valid = 1'b1; bus.mdu_rd = 5'd3; bus.mdu_data = 32'hA;
    tick();
    bus.mdu_rd = 5'd4; bus.mdu_data = 32'hB;
    tick();
    bus.mdu_valid = 1'b0;
    chk("pp_count", 32'(bus.fifo_count), 32'd1);
    chk("pp_first_rd", 32'(bus.rf_rd), 32'd3);
    chk("pp_first_wd", bus.rf_wd, 32'hA);
    tick();
    chk("pp_second_rd", 32'(bus.rf_rd), 32'd4);
    chk("pp_second_wd", bus.rf_wd, 32'hB);
    chk("pp_count0", 32'(bus.fifo_count), 32'd0);

    // Continuous pipeline writes starve a full FIFO until the stall fires.
    bus.wb_we = 1'b1; bus.wb_rd = 5'd7; bus.wb_data = 32'h77;
    bus.mdu_valid = 1'b1; bus.mdu_rd = 5'd10; bus.mdu_data = 32'h1010;
    tick();
    bus.mdu_rd = 5'd11; bus.mdu_data = 32'h1111;
    tick();
    bus.mdu_valid = 1'b0;
    chk("st_count2", 32'(bus.fifo_count), 32'd2);
    chk("st_not_ready", 32'(bus.mdu_ready), 32'd0);
    chk("st_no_stall_yet", 32'(bus.pipe_stall), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("st_stall_cyc%0d", i), 32'(bus.pipe_stall), (i == 2) ? 32'd1 : 32'd0);
    end
    bus.wb_rd = 5'd8; bus.wb_data = 32'hDEAD;
    tick();
    chk("st_head_rd", 32'(bus.rf_rd), 32'd10);
    chk("st_head_wd", bus.rf_wd, 32'h1010);
    chk("st_count1", 32'(bus.fifo_count), 32'd1);
    chk("st_stall_drop", 32'(bus.pipe_stall), 32'd0);
    bus.wb_we = 1'b0;
    tick();
    chk("st_tail_rd", 32'(bus.rf_rd), 32'd11);
    chk("st_tail_wd", bus.rf_wd, 32'h1111);

    // Asynchronous reset flushes a full FIFO and the scoreboard.
    bus.mdu_issue = 1'b1; bus.mdu_issue_rd = 5'd12;
    tick();
    bus.mdu_issue_rd = 5'd13;
    tick();
    bus.mdu_issue = 1'b0;
    bus.wb_we = 1'b1; bus.wb_rd = 5'd7; bus.wb_data = 32'h70;
    bus.mdu_valid = 1'b1; bus.mdu_rd = 5'd12; bus.mdu_data = 32'hC;
    tick();
    bus.mdu_rd = 5'd13; bus.mdu_data = 32'hD;
    tick();
    bus.mdu_valid = 1'b0;
    chk("rs_count2", 32'(bus.fifo_count), 32'd2);
    chk("rs_pend", bus.pend_mask, 32'h0000_3000);
    reset = 1'b1;
    #1;
    chk_reset_vals("async");
    tick();
    reset = 1'b0;
    idle_in();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rs_no_write%0d", i), 32'(bus.rf_we), 32'd0);
    end

    // Random traffic against the model; issue only to non-pending registers.
    for (int c = 0; c < 3000; c++) begin
      bus.wb_we     = ($urandom_range(0, 9) < 7);
      bus.wb_rd     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      bus.wb_data   = $urandom;
      bus.mdu_valid = ($urandom_range(0, 1) == 1);
      bus.mdu_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      bus.mdu_data  = $urandom;
      r = 5'($urandom_range(1, 31));
      bus.mdu_issue    = ($urandom_range(0, 3) == 0) && !m_pend[r];
      bus.mdu_issue_rd = r;
      bus.dec_rs = 5'($urandom_range(0, 31));
      bus.dec_rt = 5'($urandom_range(0, 31));
      bus.dec_rd = 5'($urandom_range(0, 31));
      tick();
    end

    idle_in();
    tick();
    @(posedge clock);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
